// File: rtl/idwt_cell.sv
// One-stage inverse DWT synthesis cell. Each approximation/detail pair is upsampled
// and filtered in polyphase form, producing an even sample then an odd sample.
module idwt_cell #(
  parameter int IN_WIDTH    = 12,
  parameter int COEFF_WIDTH = 12,
  parameter int MAC_WIDTH   = 26,
  parameter int OUT_WIDTH   = 12,
  parameter int FRA_WIDTH   = 8,
  parameter int N           = 4,
  parameter logic [N*COEFF_WIDTH-1:0] G0_IN = {12'h07C, 12'h0D6, 12'h039, 12'hFDF},
  parameter logic [N*COEFF_WIDTH-1:0] G1_IN = {12'h021, 12'h039, 12'hF2A, 12'h07C}
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  a_in,
  input  logic signed [IN_WIDTH-1:0]  d_in,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] y_out,
  output logic                        out_phase
);

  localparam int Half  = N / 2;
  localparam int Depth = (Half > 1) ? Half - 1 : 1;

  typedef enum logic [1:0] {StIdle, StEven, StOdd} state_e;

  state_e state_q, state_d;

  logic signed [IN_WIDTH-1:0]  a_hist_q [Depth];
  logic signed [IN_WIDTH-1:0]  d_hist_q [Depth];
  logic signed [IN_WIDTH-1:0]  a_tap    [Half];
  logic signed [IN_WIDTH-1:0]  d_tap    [Half];
  logic signed [MAC_WIDTH-1:0] even_sum, odd_sum;
  logic        [OUT_WIDTH-1:0] even_r, odd_r;
  logic        [OUT_WIDTH-1:0] y_q, odd_hold_q;
  logic                        accept;

  function automatic logic signed [MAC_WIDTH-1:0] mul(
    input logic signed [IN_WIDTH-1:0]    x,
    input logic signed [COEFF_WIDTH-1:0] c
  );
    logic signed [IN_WIDTH+COEFF_WIDTH-1:0] p;
    p = x * c;
    return MAC_WIDTH'(p);
  endfunction

  assign in_ready = (state_q != StEven);
  assign accept   = in_valid & in_ready;

  // Tap 0 is the live input; older taps come from the history registers.
  always_comb begin
    a_tap[0] = a_in;
    d_tap[0] = d_in;
    for (int j = 1; j < Half; j++) begin
      a_tap[j] = a_hist_q[j-1];
      d_tap[j] = d_hist_q[j-1];
    end
  end

  always_comb begin
    even_sum = '0;
    odd_sum  = '0;
    for (int j = 0; j < Half; j++) begin
      even_sum = even_sum
               + mul(a_tap[j], $signed(G0_IN[(2*j)*COEFF_WIDTH +: COEFF_WIDTH]))
               + mul(d_tap[j], $signed(G1_IN[(2*j)*COEFF_WIDTH +: COEFF_WIDTH]));
      odd_sum  = odd_sum
               + mul(a_tap[j], $signed(G0_IN[(2*j+1)*COEFF_WIDTH +: COEFF_WIDTH]))
               + mul(d_tap[j], $signed(G1_IN[(2*j+1)*COEFF_WIDTH +: COEFF_WIDTH]));
    end
  end

  // Round half up, then wrap to the output width.
  assign even_r = even_sum[FRA_WIDTH +: OUT_WIDTH] + OUT_WIDTH'(even_sum[FRA_WIDTH-1]);
  assign odd_r  = odd_sum[FRA_WIDTH +: OUT_WIDTH] + OUT_WIDTH'(odd_sum[FRA_WIDTH-1]);

  logic unused_sum_bits;
  assign unused_sum_bits = ^{even_sum[MAC_WIDTH-1:FRA_WIDTH+OUT_WIDTH],
                             odd_sum[MAC_WIDTH-1:FRA_WIDTH+OUT_WIDTH],
                             even_sum[FRA_WIDTH-2:0], odd_sum[FRA_WIDTH-2:0]};

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_phase = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StEven;
      end
      StEven: begin
        out_valid = 1'b1;
        state_d   = StOdd;
      end
      StOdd: begin
        out_valid = 1'b1;
        out_phase = 1'b1;
        state_d   = accept ? StEven : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      y_q        <= '0;
      odd_hold_q <= '0;
      for (int j = 0; j < Depth; j++) begin
        a_hist_q[j] <= '0;
        d_hist_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        y_q         <= even_r;
        odd_hold_q  <= odd_r;
        a_hist_q[0] <= a_in;
        d_hist_q[0] <= d_in;
        for (int j = 1; j < Depth; j++) begin
          a_hist_q[j] <= a_hist_q[j-1];
          d_hist_q[j] <= d_hist_q[j-1];
        end
      end else if (state_q == StEven) begin
        y_q <= odd_hold_q;
      end
    end
  end

  assign y_out = $signed(y_q);

endmodule

// File: tb/tb_idwt_cell.sv
// Self-checking bench for idwt_cell: scoreboard of expected samples checked by a
// negedge monitor, plus reset, backpressure, rounding/wrap and loopback scenarios.
module tb_idwt_cell;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [11:0] a_in = '0;
  logic signed [11:0] d_in = '0;
  logic               out_valid;
  logic signed [11:0] y_out;
  logic               out_phase;

  idwt_cell dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .d_in      (d_in),
    .out_valid (out_valid),
    .y_out     (y_out),
    .out_phase (out_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   y;
    logic ph;
    int   tol;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   fails = 0;
  int   acc_cnt = 0;
  int   valid_cnt = 0;
  int   streak = 0;
  int   max_streak = 0;
  int   ma1 = 0;
  int   md1 = 0;
  int   g0[4] = '{-33, 57, 214, 124};
  int   g1[4] = '{124, -214, 57, 33};

  function automatic int rnd(input int s);
    int t;
    logic signed [11:0] r;
    t = (s + 128) >>> 8;
    r = t[11:0];
    return int'(r);
  endfunction

  task automatic push_exp(input int y, input logic ph, input int tol);
    exp_t e;
    e.y = y; e.ph = ph; e.tol = tol;
    expq.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    int   diff;
    forever begin
      @(negedge clk);
      if (in_valid === 1'b1 && in_ready === 1'b1) acc_cnt++;
      if (out_valid === 1'b1) begin
        valid_cnt++;
        streak++;
        if (streak > max_streak) max_streak = streak;
        checks++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output y_out=%0d phase=%0b required no output",
                   y_out, out_phase);
        end else begin
          e = expq.pop_front();
          diff = int'(y_out) - e.y;
          if ($isunknown(y_out) || diff > e.tol || diff < -e.tol || out_phase !== e.ph) begin
            fails++;
            $display("FAIL sample y_out=%0d phase=%0b required y=%0d(+-%0d) phase=%0b",
                     y_out, out_phase, e.y, e.tol, e.ph);
          end
        end
      end else begin
        streak = 0;
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    a_in = '0;
    d_in = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expq.delete();
    ma1 = 0;
    md1 = 0;
    rst_n = 1'b1;
  endtask

  // Drives one pair and returns just after the clock edge that accepts it.
  task automatic send(input int a, input int d, input bit use_model);
    int n;
    if (use_model) begin
      push_exp(rnd(a * g0[0] + ma1 * g0[2] + d * g1[0] + md1 * g1[2]), 1'b0, 0);
      push_exp(rnd(a * g0[1] + ma1 * g0[3] + d * g1[1] + md1 * g1[3]), 1'b1, 0);
    end
    ma1 = a;
    md1 = d;
    a_in = 12'(a);
    d_in = 12'(d);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL send_timeout in_ready=%b required 1 within 8 cycles", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL %s_drained pending=%0d required 0", name, expq.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    wait_cycles(3);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready got=%b required 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid got=%b required 0", out_valid);
    end
    checks++;
    if (y_out !== 12'sd0) begin
      fails++; $display("FAIL reset_y_out got=%0d required 0", y_out);
    end
  endtask

  task automatic test_approx_impulse();
    do_reset();
    push_exp(-13, 1'b0, 0);
    push_exp(22, 1'b1, 0);
    push_exp(84, 1'b0, 0);
    push_exp(48, 1'b1, 0);
    send(100, 0, 1'b0);
    send(0, 0, 1'b0);
    wait_cycles(4);
    check_drained("approx");
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || y_out !== 12'sd48) begin
      fails++;
      $display("FAIL approx_hold out_valid=%b y_out=%0d required 0 and 48", out_valid, y_out);
    end
  endtask

  task automatic test_detail_impulse();
    do_reset();
    push_exp(48, 1'b0, 0);
    push_exp(-84, 1'b1, 0);
    push_exp(22, 1'b0, 0);
    push_exp(13, 1'b1, 0);
    send(0, 100, 1'b0);
    send(0, 0, 1'b0);
    wait_cycles(4);
    check_drained("detail");
  endtask

  task automatic test_rounding_wrap();
    // Even sums of exactly +128 and -128, odd sums of -218 and +218.
    do_reset();
    push_exp(1, 1'b0, 0);
    push_exp(-1, 1'b1, 0);
    send(60, 17, 1'b0);
    wait_cycles(3);
    check_drained("round_pos");
    do_reset();
    push_exp(0, 1'b0, 0);
    push_exp(1, 1'b1, 0);
    send(-60, -17, 1'b0);
    wait_cycles(3);
    check_drained("round_neg");
    // Steady full-scale input drives the odd sum far past the output range.
    do_reset();
    for (int i = 0; i < 4; i++) send(2047, -2048, 1'b1);
    wait_cycles(4);
    check_drained("wrap");
  endtask

  task automatic test_back_to_back();
    int acc0, v0;
    do_reset();
    acc0 = acc_cnt;
    v0 = valid_cnt;
    max_streak = 0;
    for (int i = 0; i < 6; i++)
      send(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048, 1'b1);
    wait_cycles(5);
    check_drained("b2b");
    checks++;
    if (acc_cnt - acc0 != 6) begin
      fails++; $display("FAIL b2b_accepts got=%0d required 6", acc_cnt - acc0);
    end
    checks++;
    if (valid_cnt - v0 != 12 || max_streak != 12) begin
      fails++;
      $display("FAIL b2b_continuous valid=%0d streak=%0d required 12 and 12",
               valid_cnt - v0, max_streak);
    end
  endtask

  task automatic test_reset_mid_even();
    int v0;
    do_reset();
    send(100, 0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_phase !== 1'b0) begin
      fails++;
      $display("FAIL midrst_even out_valid=%b phase=%b required 1 and 0", out_valid, out_phase);
    end
    v0 = valid_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || y_out !== 12'sd0) begin
      fails++;
      $display("FAIL midrst_drop out_valid=%b y_out=%0d required 0 and 0", out_valid, y_out);
    end
    wait_cycles(2);
    rst_n = 1'b1;
    ma1 = 0;
    md1 = 0;
    wait_cycles(4);
    checks++;
    if (valid_cnt != v0) begin
      fails++; $display("FAIL midrst_no_odd outputs=%0d required 0", valid_cnt - v0);
    end
  endtask

  task automatic test_loopback();
    int x[48];
    int av[24];
    int dv[24];
    int sa, sd, idx;
    do_reset();
    for (int i = 0; i < 48; i++) x[i] = int'($urandom_range(2048)) - 1024;
    // Analysis with time-reversed synthesis filters, delayed by N-1 to stay causal.
    for (int m = 0; m < 24; m++) begin
      sa = 0;
      sd = 0;
      for (int k = 0; k < 4; k++) begin
        idx = 2 * m + k - 3;
        if (idx >= 0) begin
          sa += g0[k] * x[idx];
          sd += g1[k] * x[idx];
        end
      end
      av[m] = rnd(sa);
      dv[m] = rnd(sd);
    end
    for (int n = 0; n < 48; n++) push_exp((n >= 3) ? x[n-3] : 0, n[0], 2);
    for (int m = 0; m < 24; m++) send(av[m], dv[m], 1'b0);
    wait_cycles(4);
    check_drained("loopback");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_approx_impulse();
    test_detail_impulse();
    test_rounding_wrap();
    test_back_to_back();
    test_reset_mid_even();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
